ball_game_ctrl: RTL
===================

// Module: ball_game_ctrl
// PURPOSE
//  Game sequencer for the VGA pong ball datapath: serve/play/miss/game-over FSM.
//  Gates ball motion to a frame-rate tick, holds the ball in reset between serves,
//  counts paddle hits (score) and lives, and raises X/Y step speed with level.
//  Sits between the VGA timing generator (frame pulse), the ball block (flags in,
//  reset/steps out) and the score/HUD display.
// PARAMETERS
//  LIVES_INIT      3   lives loaded on game start (1..3)
//  MOVE_DIV        2   frames per ball move tick (1..15)
//  SERVE_FRAMES    60  frames the ball is held centred before each serve
//  HITS_PER_LEVEL  5   paddle hits per speed-level increment
//  STEP_INIT       2   X/Y step at level 0
//  STEP_MAX        8   step saturation value (<=15)
// PORTS
//  iCLK        in   1  system clock
//  iRST        in   1  asynchronous active-high reset
//  iStart      in   1  debounced start button, one-cycle pulse
//  iFrame      in   1  frame-start strobe from VGA timing, one cycle per frame
//  iFlag       in   4  ball flags {Y[3:2],X[1:0]}; 2'b11 in both = ball lost
//  oBall_RST_n out  1  active-low reset to ball block (holds ball at centre)
//  oMove_Tick  out  1  one-cycle ball update strobe (ball clock-enable)
//  oX_Step     out  4  current X step
//  oY_Step     out  4  current Y step
//  oScore      out  8  paddle hit count, saturates at 8'hFF
//  oLives      out  2  remaining lives
//  oState      out  3  FSM state code (HUD/debug)
//  oGame_Over  out  1  high while in OVER
// BEHAVIOUR
//  Interface: one clock iCLK; reset iRST asynchronous, active-high; all outputs registered.
//  Reset: state=IDLE, oBall_RST_n=0, oMove_Tick=0, steps=STEP_INIT, oScore=0,
//   oLives=LIVES_INIT, oGame_Over=0, frame/serve/hit counters=0.
//  States: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4, PAUSE=5 (macro only).
//  IDLE : oBall_RST_n=0. iStart -> SERVE; score, level, steps, lives reloaded.
//  SERVE: oBall_RST_n=0; count iFrame; after SERVE_FRAMES frames -> PLAY
//   (oBall_RST_n=1 from first PLAY cycle).
//  PLAY : oMove_Tick pulses the cycle after every MOVE_DIV-th iFrame.
//   Hit = iFlag[3:2] changes to 2'b01 (edge vs last sampled value; held flag
//   counts once). Hit: oScore+1 (sat), hit counter+1; on reaching HITS_PER_LEVEL
//   counter clears, X/Y steps +1 saturating at STEP_MAX.
//   iFlag==4'b1111 -> MISS, oLives-1 in the same transition.
//  MISS : one cycle; oLives==0 -> OVER, else -> SERVE (steps kept).
//  OVER : oGame_Over=1, oBall_RST_n=0; iStart -> SERVE with full reload.
//  Priority in PLAY same cycle: miss > hit (no score on lost-ball cycle).
//  iStart ignored in SERVE/PLAY/MISS. iFrame and hit coincident: both processed.
//  oMove_Tick never asserted outside PLAY; frame divider clears on PLAY entry.
//  iRST mid-game: immediate return to reset values, no pending tick.
// CONFIGURATION
//  GAME_PAUSE_EN defined: extra input iPause (1-cycle pulse); PLAY<->PAUSE toggle;
//   PAUSE freezes oMove_Tick, divider and hit detection, oBall_RST_n stays 1.
//  Undefined: no iPause port, PAUSE code 5 unreachable, iStart sole control.
// STRUCTURE
//  Package ball_game_pkg: state encoding localparams, flag codes
//   (FLAG_PADDLE=2'b01, FLAG_LOST=4'b1111), STEP width constant.
//  Sub-module frame_divider: iFrame counter -> oMove_Tick, clear/enable inputs.
//  FSM, hit edge detector, score/level/lives counters in this module.
// TESTING
//  Reset then iStart -> SERVE for 60 frames, oBall_RST_n=0, then PLAY, ball released.
//  PLAY, MOVE_DIV=2, 10 iFrame pulses -> exactly 5 oMove_Tick pulses.
//  5 paddle edges (iFlag[3:2]=01, held 3 cycles each) -> oScore=5, steps 2->3.
//  iFlag=4'b1111 three times with serves between -> lives 3,2,1,0, OVER, oGame_Over=1.
//  Hit and lost same cycle -> score unchanged, lives-1; 40 hits -> steps stay 8.
//  iRST during PLAY with oScore=7 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ball_game_pkg.sv
// ----------------------------------------------------------------------------
// ball_game_pkg
// Shared definitions for the pong game sequencer.
//   state_t      FSM state codes, also shown on the HUD/debug state output
//   FLAG_PADDLE  Y-flag code meaning the ball touched the paddle
//   FLAG_LOST    full flag code meaning the ball left the field
//   STEP_W       width of the X/Y step values
//   step_inc     saturating increment used when the speed level rises
// ----------------------------------------------------------------------------
package ball_game_pkg;

    localparam int STEP_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

    localparam logic [1:0] FLAG_PADDLE = 2'b01;
    localparam logic [3:0] FLAG_LOST   = 4'b1111;

    function automatic logic [STEP_W-1:0] step_inc(input logic [STEP_W-1:0] cur,
                                                   input logic [STEP_W-1:0] lim);
        return (cur >= lim) ? lim : cur + 1'b1;
    endfunction

endpackage

// File: rtl/ball_game_ctrl_frame_divider.sv
// ----------------------------------------------------------------------------
// frame_divider
// Counts frame strobes and emits a one-cycle registered move tick on the
// cycle after every MOVE_DIV-th counted frame.
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   frame in  frame-start strobe
//   clr   in  synchronous clear of count and tick (highest priority)
//   en    in  count enable; when low and clr low the count is frozen
//   tick  out one-cycle move strobe
// ----------------------------------------------------------------------------
module frame_divider #(
    parameter int MOVE_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic frame,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [3:0] DIV_LAST = 4'(MOVE_DIV - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en && frame) begin
            if (cnt == DIV_LAST) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/ball_game_ctrl.sv
// ----------------------------------------------------------------------------
// ball_game_ctrl
// Serve/play/miss/game-over sequencer for the VGA pong ball datapath.
// Holds the ball centred between serves, gates ball motion to a frame-rate
// tick, counts paddle hits (score) and lives, and raises the ball step with
// the speed level (one level per HITS_PER_LEVEL hits).
//
// Optional build macro: GAME_PAUSE_EN adds the iPause input; a pulse toggles
// PLAY <-> PAUSE. PAUSE freezes the move tick, frame divider and hit detector
// while the ball stays released. Without the macro PAUSE is unreachable.
//
// Ports
//   iCLK        in  system clock
//   iRST        in  asynchronous active-high reset
//   iStart      in  start button pulse (honoured in IDLE and OVER only)
//   iFrame      in  frame-start strobe, one cycle per frame
//   iFlag[3:0]  in  ball flags {Y[3:2], X[1:0]}; 4'b1111 = ball lost
//   iPause      in  pause toggle pulse (GAME_PAUSE_EN builds only)
//   oBall_RST_n out active-low ball reset, released in PLAY/PAUSE
//   oMove_Tick  out one-cycle ball update strobe
//   oX_Step     out current X step
//   oY_Step     out current Y step
//   oScore      out paddle hit count, saturating at 8'hFF
//   oLives      out remaining lives
//   oState      out FSM state code
//   oGame_Over  out high while in OVER
// ----------------------------------------------------------------------------
module ball_game_ctrl
    import ball_game_pkg::*;
#(
    parameter int LIVES_INIT     = 3,
    parameter int MOVE_DIV       = 2,
    parameter int SERVE_FRAMES   = 60,
    parameter int HITS_PER_LEVEL = 5,
    parameter int STEP_INIT      = 2,
    parameter int STEP_MAX       = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iStart,
    input  logic              iFrame,
    input  logic [3:0]        iFlag,
`ifdef GAME_PAUSE_EN
    input  logic              iPause,
`endif
    output logic              oBall_RST_n,
    output logic              oMove_Tick,
    output logic [STEP_W-1:0] oX_Step,
    output logic [STEP_W-1:0] oY_Step,
    output logic [7:0]        oScore,
    output logic [1:0]        oLives,
    output logic [2:0]        oState,
    output logic              oGame_Over
);

    localparam logic [15:0]       SERVE_LAST = 16'(SERVE_FRAMES - 1);
    localparam logic [7:0]        HIT_LAST   = 8'(HITS_PER_LEVEL - 1);
    localparam logic [STEP_W-1:0] STEP_RST   = STEP_W'(STEP_INIT);
    localparam logic [STEP_W-1:0] STEP_LIM   = STEP_W'(STEP_MAX);
    localparam logic [1:0]        LIVES_RST  = 2'(LIVES_INIT);

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       serve_cnt;
    logic [7:0]        hit_cnt;
    logic [STEP_W-1:0] step;
    logic [1:0]        flag_y_prev;

    logic              reload;
    logic              lose_life;
    logic              hit;
    logic              serve_done;
    logic              paddle_edge;
    logic              lost;
    logic              div_clr;
    logic              div_en;

    // A held paddle flag counts once: only a change into the paddle code is a hit.
    assign paddle_edge = (iFlag[3:2] == FLAG_PADDLE) && (flag_y_prev != FLAG_PADDLE);
    assign lost        = (iFlag == FLAG_LOST);
    assign serve_done  = iFrame && (serve_cnt == SERVE_LAST);

    always_comb begin
        state_nxt = state;
        reload    = 1'b0;
        lose_life = 1'b0;
        hit       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iStart) begin
                    state_nxt = ST_SERVE;
                    reload    = 1'b1;
                end
            end
            ST_SERVE: begin
                if (serve_done) state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                // A lost ball wins over any hit seen in the same cycle.
                if (lost) begin
                    state_nxt = ST_MISS;
                    lose_life = 1'b1;
                end else begin
                    hit = paddle_edge;
`ifdef GAME_PAUSE_EN
                    if (iPause) state_nxt = ST_PAUSE;
`endif
                end
            end
            ST_MISS: begin
                state_nxt = (oLives == 2'd0) ? ST_OVER : ST_SERVE;
            end
            ST_OVER: begin
                if (iStart) begin
                    state_nxt = ST_SERVE;
                    reload    = 1'b1;
                end
            end
            ST_PAUSE: begin
`ifdef GAME_PAUSE_EN
                if (iPause) state_nxt = ST_PLAY;
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Divider counts only while PLAY continues, so no tick can land in MISS or
    // PAUSE; it is cleared everywhere except PLAY/PAUSE so each serve starts fresh.
    assign div_en  = (state == ST_PLAY) && (state_nxt == ST_PLAY);
    assign div_clr = (state != ST_PLAY) && (state != ST_PAUSE);

    frame_divider #(
        .MOVE_DIV (MOVE_DIV)
    ) u_frame_divider (
        .clk   (iCLK),
        .rst   (iRST),
        .frame (iFrame),
        .clr   (div_clr),
        .en    (div_en),
        .tick  (oMove_Tick)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state       <= ST_IDLE;
            serve_cnt   <= '0;
            hit_cnt     <= '0;
            step        <= STEP_RST;
            oScore      <= '0;
            oLives      <= LIVES_RST;
            flag_y_prev <= '0;
            oBall_RST_n <= 1'b0;
            oGame_Over  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state != ST_PAUSE) flag_y_prev <= iFlag[3:2];

            if (state != ST_SERVE)      serve_cnt <= '0;
            else if (serve_done)        serve_cnt <= '0;
            else if (iFrame)            serve_cnt <= serve_cnt + 1'b1;

            if (reload) begin
                oScore  <= '0;
                hit_cnt <= '0;
                step    <= STEP_RST;
                oLives  <= LIVES_RST;
            end else if (lose_life) begin
                oLives <= (oLives != 2'd0) ? oLives - 1'b1 : 2'd0;
            end else if (hit) begin
                if (oScore != 8'hFF) oScore <= oScore + 1'b1;
                if (hit_cnt == HIT_LAST) begin
                    hit_cnt <= '0;
                    step    <= step_inc(step, STEP_LIM);
                end else begin
                    hit_cnt <= hit_cnt + 1'b1;
                end
            end

            // Registered from the next state so the ball is released on the
            // very first PLAY cycle and OVER is flagged on entry.
            oBall_RST_n <= (state_nxt == ST_PLAY) || (state_nxt == ST_PAUSE);
            oGame_Over  <= (state_nxt == ST_OVER);
        end
    end

    assign oX_Step = step;
    assign oY_Step = step;
    assign oState  = state;

endmodule
